shake_squeeze: RTL
==================

SHAKE_SQUEEZE -- requirements
Module: shake_squeeze

Interface
REQ-001 Parameter: LANE_W, 64, width of one Keccak lane and of dout.
REQ-002 Parameter: LEN_W, 16, width of the out_len word counter.
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-low reset; assertion clears all state immediately, independent of clk.
REQ-005 Port: start  in  1  one-cycle request to begin a squeeze.
REQ-006 Port: out_len  in  LEN_W  number of 64-bit words to produce; sampled on accepted start.
REQ-007 Port: rate_sel  in  1  0 = SHAKE128 (21 rate lanes), 1 = SHAKE256 (17 rate lanes); sampled on accepted start.
REQ-008 Port: in_state  in  1600  permuted state from the upstream permutation; lane i = in_state[64i+:64].
REQ-009 Port: in_valid  in  1  in_state is valid.
REQ-010 Port: in_ready  out  1  block accepts in_state.
REQ-011 Port: perm_go  out  1  one-cycle request for one 24-round permutation of perm_state_in.
REQ-012 Port: perm_state_in  out  1600  state to permute; equals the held buffer.
REQ-013 Port: perm_done  in  1  one-cycle pulse; perm_state_out is valid.
REQ-014 Port: perm_state_out  in  1600  permutation result.
REQ-015 Port: dout  out  LANE_W  current output lane, lane order, bytes unchanged.
REQ-016 Port: dout_valid  out  1  dout is valid.
REQ-017 Port: dout_ready  in  1  downstream accepts dout.
REQ-018 Port: dout_last  out  1  high with dout_valid on the final requested word.
REQ-019 Port: busy  out  1  high in every state except IDLE.
REQ-020 Port: done  out  1  one-cycle pulse after the final word handshake.

Function
REQ-021 The FSM SHALL have states IDLE, LOAD, STREAM, and PERM.
REQ-022 IDLE: start with out_len != 0 SHALL latch out_len and rate_sel and go to LOAD; start with out_len == 0 SHALL be ignored.
REQ-023 LOAD: in_ready SHALL be 1; on in_valid & in_ready the state SHALL be captured into the 1600-bit buffer, lane_idx SHALL be set to 0, and the FSM SHALL go to STREAM.
REQ-024 STREAM: dout_valid = 1 and dout = buffer lane[lane_idx]; the first dout_valid SHALL appear in the cycle after capture.
REQ-025 A handshake is dout_valid & dout_ready; on each handshake words_left SHALL decrement.
REQ-026 On the handshake with words_left == 1: dout_last SHALL have been high for that word, done SHALL pulse the next cycle, and the FSM SHALL go to IDLE.
REQ-027 Otherwise, on a handshake with lane_idx == RATE-1 (20 or 16): the FSM SHALL go to PERM, lane_idx SHALL reset to 0, and perm_go SHALL be high for exactly the next cycle.
REQ-028 Otherwise, on a handshake, lane_idx SHALL increment.
REQ-029 dout and dout_last SHALL hold stable while dout_valid & !dout_ready; dout_valid SHALL never drop without a handshake.
REQ-030 PERM: dout_valid = 0 and perm_state_in SHALL be stable; on perm_done, perm_state_out SHALL be captured into the buffer and the FSM SHALL go to STREAM, with dout_valid in the following cycle.
REQ-031 perm_done outside PERM SHALL be ignored, and in_valid outside LOAD SHALL be ignored.
REQ-032 start while busy SHALL be ignored, and the latched out_len/rate_sel SHALL be unchanged.
REQ-033 The block-permutation count SHALL be exactly ceil(out_len / RATE) - 1 perm_go pulses per request.
REQ-034 The lane index SHALL never exceed RATE-1, and capacity lanes SHALL never appear on dout.

Reset
REQ-035 On rst low: FSM = IDLE; buffer, lane_idx, and words_left = 0; in_ready, perm_go, dout_valid, dout_last, busy, and done = 0; dout = 0.
REQ-036 Reset mid-operation (any state) SHALL abort without a further perm_go or done; after rst rises, the block SHALL accept a new start.

Verification
REQ-037 Setup: in_state lane i = i, rate_sel=0, out_len=3, dout_ready=1 -> dout = 0, 1, 2 on consecutive cycles; dout_last on 2; done one cycle later; perm_go never asserted.
REQ-038 Setup: rate_sel=0, out_len=22 -> lanes 0..20 out, then a perm_go pulse with perm_state_in == captured state; bench answers perm_done after 24 cycles with lane i = 100+i -> next dout = 100 with dout_last=1.
REQ-039 Setup: rate_sel=1, out_len=18 -> perm_go after the 17th word (dout = 16); 18th word = first lane of the new state; lanes 17..24 never output.
REQ-040 Setup: out_len=4, dout_ready low for 5 cycles at word 1 -> dout holds 1 and dout_valid stays high; the sequence resumes with no lost or duplicated word.
REQ-041 Setup: rst low during PERM -> all outputs 0 immediately; a later perm_done is ignored; a new start with out_len=1 yields a single word, dout_last and done.
REQ-042 Setup: start with out_len=0 in IDLE, then start during STREAM -> both ignored; busy and the word count unaffected.

Source files
------------

// File: rtl/shake_squeeze.sv
// SHAKE output squeezer: captures a permuted Keccak state, streams its rate lanes,
// and requests further permutations until the requested number of words is produced.
module shake_squeeze #(
  parameter int unsigned LANE_W = 64,
  parameter int unsigned LEN_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      out_len,
  input  logic                  rate_sel,
  input  logic [25*LANE_W-1:0]  in_state,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  perm_go,
  output logic [25*LANE_W-1:0]  perm_state_in,
  input  logic                  perm_done,
  input  logic [25*LANE_W-1:0]  perm_state_out,
  output logic [LANE_W-1:0]     dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned LANES   = 25;
  localparam int unsigned STATE_W = LANES * LANE_W;
  localparam int unsigned IDX_W   = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    PERM   = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [STATE_W-1:0] buffer, buffer_d;
  logic [IDX_W-1:0]   lane_idx, lane_d;
  logic [LEN_W-1:0]   words_left, words_d;
  logic               rate_q, rate_d;

  logic               in_ready_d, perm_go_d, dout_valid_d, dout_last_d, busy_d, done_d;
  logic [LANE_W-1:0]  dout_d;
  logic [IDX_W-1:0]   rate_last;

  assign perm_state_in = buffer;
  assign rate_last     = rate_q ? IDX_W'(16) : IDX_W'(20);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      buffer     <= '0;
      lane_idx   <= '0;
      words_left <= '0;
      rate_q     <= 1'b0;
      in_ready   <= 1'b0;
      perm_go    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      buffer     <= buffer_d;
      lane_idx   <= lane_d;
      words_left <= words_d;
      rate_q     <= rate_d;
      in_ready   <= in_ready_d;
      perm_go    <= perm_go_d;
      dout       <= dout_d;
      dout_valid <= dout_valid_d;
      dout_last  <= dout_last_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Next-state logic; outputs are derived from the next state so they register in step
  always_comb begin
    state_d   = state;
    buffer_d  = buffer;
    lane_d    = lane_idx;
    words_d   = words_left;
    rate_d    = rate_q;
    perm_go_d = 1'b0;
    done_d    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && (out_len != '0)) begin
          words_d = out_len;
          rate_d  = rate_sel;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_valid && in_ready) begin
          buffer_d = in_state;
          lane_d   = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (dout_valid && dout_ready) begin
          words_d = words_left - LEN_W'(1);
          if (words_left == LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (lane_idx == rate_last) begin
            lane_d    = '0;
            perm_go_d = 1'b1;
            state_d   = PERM;
          end else begin
            lane_d = lane_idx + IDX_W'(1);
          end
        end
      end
      PERM: begin
        if (perm_done) begin
          buffer_d = perm_state_out;
          state_d  = STREAM;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d   = (state_d == LOAD);
    dout_valid_d = (state_d == STREAM);
    dout_last_d  = (state_d == STREAM) && (words_d == LEN_W'(1));
    busy_d       = (state_d != IDLE);
  end

  // Lane select for the next output word; lane_d never exceeds the rate
  always_comb begin
    dout_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_d == IDX_W'(i)) dout_d = buffer_d[i*LANE_W +: LANE_W];
    end
  end

endmodule
